// File: rtl/bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl
//
// Sequencing controller for the branch predictor (BTB + PHT).
//   * Holds the speculative global history register (GHR) that feeds the
//     predictor read port, shifting in each consumed prediction.
//   * Buffers resolved branches from execute in a circular queue and presents
//     the head entry to the predictor write port, one update per grant.
//   * On an accepted mispredict, restores the GHR from the resolved branch and
//     stalls fetch for RECOVER_CYC cycles.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   pred_valid          fetch consumed a prediction this cycle
//   is_taken_predict    predicted direction of that branch
//   history             speculative GHR to predictor read port
//   fetch_stall         high while recovering from a mispredict
//   res_valid/res_ready resolved-branch handshake from execute
//   res_PC/res_history/res_NPC/res_taken/res_mispredict  resolved branch data
//   upd_valid/upd_ready predictor write-port handshake
//   upd_PC/upd_history/upd_NPC/upd_taken  head-of-queue update data
//   count               number of occupied queue entries
// -----------------------------------------------------------------------------
module bp_update_ctrl #(
    parameter int PC_W        = 16,
    parameter int HIST_W      = 3,
    parameter int DEPTH       = 4,
    parameter int RECOVER_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    input  logic                       is_taken_predict,
    output logic [HIST_W-1:0]          history,
    output logic                       fetch_stall,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [PC_W-1:0]            res_PC,
    input  logic [HIST_W-1:0]          res_history,
    input  logic [PC_W-1:0]            res_NPC,
    input  logic                       res_taken,
    input  logic                       res_mispredict,
    output logic                       upd_valid,
    input  logic                       upd_ready,
    output logic [PC_W-1:0]            upd_PC,
    output logic [HIST_W-1:0]          upd_history,
    output logic [PC_W-1:0]            upd_NPC,
    output logic                       upd_taken,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int RC_W  = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HIST_W-1:0]   r_ghr;
    logic [HIST_W-1:0]   w_ghr_nxt;
    logic [RC_W-1:0]     r_rcnt;
    logic [RC_W-1:0]     w_rcnt_nxt;

    logic [PC_W-1:0]     r_pc_mem   [DEPTH];
    logic [HIST_W-1:0]   r_hist_mem [DEPTH];
    logic [PC_W-1:0]     r_npc_mem  [DEPTH];
    logic                r_tkn_mem  [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_push;
    logic                w_pop;

    // Ready depends only on registered state/count: a pop in the same cycle
    // does not free a slot for a push until the next cycle.
    assign res_ready = (r_state == S_RUN) && (r_count < CNT_W'(DEPTH));
    assign upd_valid = (r_count != '0);
    assign w_push    = res_valid && res_ready;
    assign w_pop     = upd_valid && upd_ready;

    assign upd_PC      = r_pc_mem[r_rd_ptr];
    assign upd_history = r_hist_mem[r_rd_ptr];
    assign upd_NPC     = r_npc_mem[r_rd_ptr];
    assign upd_taken   = r_tkn_mem[r_rd_ptr];
    assign count       = r_count;
    assign history     = r_ghr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_ghr   <= '0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ghr   <= w_ghr_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ghr_nxt   = r_ghr;
        w_rcnt_nxt  = r_rcnt;
        fetch_stall = 1'b0;
        case (r_state)
            S_RUN: begin
                // A mispredict overrides any speculative shift in the same cycle.
                if (w_push && res_mispredict) begin
                    w_ghr_nxt   = {res_history[HIST_W-2:0], res_taken};
                    w_rcnt_nxt  = RC_W'(RECOVER_CYC - 1);
                    w_state_nxt = S_RECOVER;
                end else if (pred_valid) begin
                    w_ghr_nxt = {r_ghr[HIST_W-2:0], is_taken_predict};
                end
            end
            S_RECOVER: begin
                fetch_stall = 1'b1;
                if (r_rcnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_rcnt_nxt = r_rcnt - RC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Update queue: pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_hist_mem[i] <= '0;
                r_npc_mem[i]  <= '0;
                r_tkn_mem[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]   <= res_PC;
                r_hist_mem[r_wr_ptr] <= res_history;
                r_npc_mem[r_wr_ptr]  <= res_NPC;
                r_tkn_mem[r_wr_ptr]  <= res_taken;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;

    localparam int PC_W        = 16;
    localparam int HIST_W      = 3;
    localparam int DEPTH       = 4;
    localparam int RECOVER_CYC = 2;
    localparam int CNT_W       = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                pred_valid;
    logic                is_taken_predict;
    logic [HIST_W-1:0]   history;
    logic                fetch_stall;
    logic                res_valid;
    logic                res_ready;
    logic [PC_W-1:0]     res_PC;
    logic [HIST_W-1:0]   res_history;
    logic [PC_W-1:0]     res_NPC;
    logic                res_taken;
    logic                res_mispredict;
    logic                upd_valid;
    logic                upd_ready;
    logic [PC_W-1:0]     upd_PC;
    logic [HIST_W-1:0]   upd_history;
    logic [PC_W-1:0]     upd_NPC;
    logic                upd_taken;
    logic [CNT_W-1:0]    count;

    int checks = 0;
    int errors = 0;

    bp_update_ctrl #(
        .PC_W(PC_W), .HIST_W(HIST_W), .DEPTH(DEPTH), .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .is_taken_predict(is_taken_predict),
        .history(history), .fetch_stall(fetch_stall),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_PC(res_PC), .res_history(res_history), .res_NPC(res_NPC),
        .res_taken(res_taken), .res_mispredict(res_mispredict),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_PC(upd_PC), .upd_history(upd_history), .upd_NPC(upd_NPC),
        .upd_taken(upd_taken), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of resolved branches, the GHR, and the number
    // of stall cycles still owed.
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic [PC_W-1:0]   npc;
        logic              taken;
    } upd_t;

    upd_t              m_q[$];
    logic [HIST_W-1:0] m_ghr;
    int                m_stall_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_ghr        = '0;
            m_stall_left = 0;
        end else begin
            bit   can_acc;
            bit   acc;
            upd_t e;
            can_acc = (m_stall_left == 0) && (m_q.size() < DEPTH);
            acc     = res_valid && can_acc;
            if (m_q.size() != 0 && upd_ready) void'(m_q.pop_front());
            if (acc) begin
                e.pc = res_PC; e.hist = res_history; e.npc = res_NPC; e.taken = res_taken;
                m_q.push_back(e);
            end
            if (m_stall_left > 0) begin
                m_stall_left--;
            end else if (acc && res_mispredict) begin
                m_ghr        = {res_history[HIST_W-2:0], res_taken};
                m_stall_left = RECOVER_CYC;
            end else if (pred_valid) begin
                m_ghr = {m_ghr[HIST_W-2:0], is_taken_predict};
            end
        end
    end

    always @(negedge clk) begin
        chk("m_history", 32'(history), 32'(m_ghr));
        chk("m_fetch_stall", 32'(fetch_stall), 32'(m_stall_left > 0));
        chk("m_count", 32'(count), 32'(m_q.size()));
        chk("m_upd_valid", 32'(upd_valid), 32'(m_q.size() != 0));
        if (rst) chk("m_res_ready", 32'(res_ready), 32'((m_stall_left == 0) && (m_q.size() < DEPTH)));
        if (m_q.size() != 0) begin
            chk("m_upd_PC", 32'(upd_PC), 32'(m_q[0].pc));
            chk("m_upd_history", 32'(upd_history), 32'(m_q[0].hist));
            chk("m_upd_NPC", 32'(upd_NPC), 32'(m_q[0].npc));
            chk("m_upd_taken", 32'(upd_taken), 32'(m_q[0].taken));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic v, input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] h,
                           input logic [PC_W-1:0] npc, input logic t, input logic m);
        res_valid = v; res_PC = pc; res_history = h; res_NPC = npc; res_taken = t; res_mispredict = m;
    endtask

    initial begin
        rst = 1'b0;
        pred_valid = 0; is_taken_predict = 0; upd_ready = 0;
        set_res(0, '0, '0, '0, 0, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_res_ready", 32'(res_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_history", 32'(history), 32'd0);

        // Speculative shift
        pred_valid = 1; is_taken_predict = 1; tick();
        chk("shift1", 32'(history), 32'h1);
        is_taken_predict = 1; tick();
        chk("shift2", 32'(history), 32'h3);
        is_taken_predict = 0; tick();
        chk("shift3", 32'(history), 32'h6);
        pred_valid = 0;

        // Drain latency
        upd_ready = 1;
        set_res(1, 16'h0040, 3'b000, 16'h0080, 1, 0);
        tick();
        set_res(0, '0, '0, '0, 0, 0);
        chk("drain_valid", 32'(upd_valid), 32'd1);
        chk("drain_PC", 32'(upd_PC), 32'h0040);
        chk("drain_NPC", 32'(upd_NPC), 32'h0080);
        tick();
        chk("drain_empty", 32'(upd_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Full / backpressure
        upd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_res(1, 16'(16'h0100 + i), 3'(i), 16'(16'h0500 + i), 1'(i), 0);
            tick();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(res_ready), 32'd0);
        set_res(1, 16'h01FF, 3'b111, 16'h05FF, 1, 0);
        tick();
        set_res(0, '0, '0, '0, 0, 0);
        chk("full_reject", 32'(count), 32'd4);
        chk("full_head", 32'(upd_PC), 32'h0100);
        upd_ready = 1; tick(); upd_ready = 0;
        chk("pop_count", 32'(count), 32'd3);
        chk("pop_ready", 32'(res_ready), 32'd1);
        chk("pop_head", 32'(upd_PC), 32'h0101);
        upd_ready = 1;
        for (int i = 1; i < 4; i++) begin
            chk("fifo_order", 32'(upd_PC), 32'(16'h0100 + i));
            tick();
        end
        upd_ready = 0;
        chk("fifo_empty", 32'(count), 32'd0);

        // Mispredict recovery
        pred_valid = 1; is_taken_predict = 1; tick();
        chk("ghr_101", 32'(history), 32'h5);
        is_taken_predict = 0;
        set_res(1, 16'h0200, 3'b010, 16'h0300, 1, 1);
        tick();
        set_res(0, '0, '0, '0, 0, 0);
        is_taken_predict = 1;
        chk("mp_ghr", 32'(history), 32'h5);
        chk("mp_stall1", 32'(fetch_stall), 32'd1);
        chk("mp_ready1", 32'(res_ready), 32'd0);
        chk("mp_upd_hist", 32'(upd_history), 32'h2);
        upd_ready = 1;
        tick();
        chk("mp_stall2", 32'(fetch_stall), 32'd1);
        chk("mp_drain", 32'(count), 32'd0);
        upd_ready = 0;
        tick();
        pred_valid = 0;
        chk("mp_stall_end", 32'(fetch_stall), 32'd0);
        chk("mp_ghr_held", 32'(history), 32'h5);
        chk("mp_ready_back", 32'(res_ready), 32'd1);

        // Simultaneous push/pop across the wrap
        set_res(1, 16'h0300, 3'b001, 16'h0400, 0, 0); tick();
        set_res(1, 16'h0301, 3'b010, 16'h0401, 1, 0); tick();
        chk("wrap_pre", 32'(count), 32'd2);
        upd_ready = 1;
        for (int k = 2; k < 5; k++) begin
            set_res(1, 16'(16'h0300 + k), 3'(k), 16'(16'h0400 + k), 1'(k), 0);
            tick();
            chk("wrap_count", 32'(count), 32'd2);
            chk("wrap_head", 32'(upd_PC), 32'(16'h0300 + k - 1));
        end
        set_res(0, '0, '0, '0, 0, 0);
        tick(); tick();
        upd_ready = 0;
        chk("wrap_drained", 32'(count), 32'd0);

        // Reset mid-operation: two queued entries and recovery in progress
        set_res(1, 16'h0600, 3'b011, 16'h0700, 0, 0); tick();
        set_res(1, 16'h0601, 3'b100, 16'h0701, 1, 1); tick();
        set_res(0, '0, '0, '0, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_stall", 32'(fetch_stall), 32'd1);
        rst = 1'b0;
        tick();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(upd_valid), 32'd0);
        chk("mid_rst_hist", 32'(history), 32'd0);
        chk("mid_rst_stall", 32'(fetch_stall), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(res_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
